// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM duty ramp sequencer.
// Holds the duty width, the duty typedef, the ramp FSM state enum and
// the saturating step function used to walk the duty toward its target.
package pwm_pkg;

  localparam int PWM_DUTY_W = 8;

  typedef logic [PWM_DUTY_W-1:0] pwm_duty_t;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } pwm_ramp_state_t;

  // Move cur one step toward tgt. The difference is taken at 9 bits so a
  // large gap never wraps, and a gap no larger than the step snaps straight
  // onto the target, which keeps the result inside 0..255.
  function automatic pwm_duty_t pwm_step_toward(input pwm_duty_t cur,
                                                input pwm_duty_t tgt,
                                                input pwm_duty_t step);
    logic [PWM_DUTY_W:0] diff;
    pwm_duty_t           result;
    if (tgt >= cur) begin
      diff = {1'b0, tgt} - {1'b0, cur};
      if (diff <= {1'b0, step}) begin
        result = tgt;
      end else begin
        result = cur + step;
      end
    end else begin
      diff = {1'b0, cur} - {1'b0, tgt};
      if (diff <= {1'b0, step}) begin
        result = tgt;
      end else begin
        result = cur - step;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/pwm_tick_div.sv
// Period-tick divider: counts PWM period ticks and emits a one-cycle
// step_en on every div-th tick (div of 0 behaves as 1). step_en is
// combinational so the step lands on the same edge as the tick that
// completes it. clear holds the count at zero and suppresses step_en.
module pwm_tick_div
  import pwm_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      tick,
  input  logic      clear,
  input  pwm_duty_t div,
  output logic      step_en
);

  pwm_duty_t cnt_q;
  pwm_duty_t cnt_d;
  pwm_duty_t last_cnt;

  assign last_cnt = (div == '0) ? '0 : div - pwm_duty_t'(1);

  // Next count and step strobe; clear wins over any tick.
  always_comb begin
    cnt_d   = cnt_q;
    step_en = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (tick) begin
      if (cnt_q == last_cnt) begin
        step_en = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + pwm_duty_t'(1);
      end
    end
  end

  // Tick counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pwm_ramp_sequencer.sv
// Soft-start / soft-change controller for the PWM generator duty input.
// Accepts a target duty over valid/ready and walks duty_cycle toward it by
// STEP every DIV period ticks, so duty only changes on period boundaries.
// Optional feature: define PWM_RAMP_ABORT_EN to add an abort input that
// forces duty and target to 0 and returns to IDLE without a done pulse.
module pwm_ramp_sequencer
  import pwm_pkg::*;
#(
  parameter int unsigned STEP = 4,
  parameter int unsigned DIV  = 1
) (
  input  logic      clk,
  input  logic      reset,
`ifdef PWM_RAMP_ABORT_EN
  input  logic      abort,
`endif
  input  logic      period_tick,
  input  logic      tgt_valid,
  output logic      tgt_ready,
  input  pwm_duty_t tgt_duty,
  output pwm_duty_t duty_cycle,
  output logic      busy,
  output logic      done
);

  localparam pwm_duty_t STEP_L = pwm_duty_t'(STEP);
  localparam pwm_duty_t DIV_L  = pwm_duty_t'(DIV);

  pwm_ramp_state_t state_q, state_d;
  pwm_duty_t       duty_q, duty_d;
  pwm_duty_t       target_q, target_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            div_clear;
  logic            step_en;
  pwm_duty_t       stepped_duty;

  // The divider only runs while ramping; holding it clear in IDLE also
  // makes a tick in the acceptance cycle go uncounted.
`ifdef PWM_RAMP_ABORT_EN
  assign div_clear = (state_q != RAMP) | abort;
`else
  assign div_clear = (state_q != RAMP);
`endif

  pwm_tick_div u_tick_div (
    .clk     (clk),
    .reset   (reset),
    .tick    (period_tick),
    .clear   (div_clear),
    .div     (DIV_L),
    .step_en (step_en)
  );

  assign stepped_duty = pwm_step_toward(duty_q, target_q, STEP_L);

  // Ready is decoded from state and forced low while reset is held.
  assign tgt_ready = reset & (state_q == IDLE);

  // Next-state, duty, target and status decode.
  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    target_d = target_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tgt_valid) begin
          if (tgt_duty != duty_q) begin
            target_d = tgt_duty;
            state_d  = RAMP;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RAMP: begin
        if (step_en) begin
          duty_d = stepped_duty;
          if (stepped_duty == target_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
`ifdef PWM_RAMP_ABORT_EN
    if (abort) begin
      state_d  = IDLE;
      duty_d   = '0;
      target_d = '0;
      done_d   = 1'b0;
    end
`endif
    busy_d = (state_d == RAMP);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      duty_q   <= '0;
      target_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign duty_cycle = duty_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Directed bench for pwm_ramp_sequencer. Three instances cover
// STEP=4/DIV=1, STEP=64/DIV=1 and STEP=4/DIV=3. The abort scenario is
// compiled in when PWM_RAMP_ABORT_EN is defined.
module tb_pwm_ramp_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       period_tick;
`ifdef PWM_RAMP_ABORT_EN
  logic       abort;
`endif

  logic       valid_a, ready_a, busy_a, done_a;
  logic [7:0] tduty_a, duty_a;
  logic       valid_b, ready_b, busy_b, done_b;
  logic [7:0] tduty_b, duty_b;
  logic       valid_c, ready_c, busy_c, done_c;
  logic [7:0] tduty_c, duty_c;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt_a = 0;

  int up_b[4]   = '{64, 128, 192, 200};
  int down_b[3] = '{136, 72, 10};
  int seq_c[6]  = '{0, 0, 4, 4, 4, 8};

  pwm_ramp_sequencer #(.STEP(4), .DIV(1)) u_dut_a (
    .clk(clk), .reset(reset),
`ifdef PWM_RAMP_ABORT_EN
    .abort(abort),
`endif
    .period_tick(period_tick), .tgt_valid(valid_a), .tgt_ready(ready_a),
    .tgt_duty(tduty_a), .duty_cycle(duty_a), .busy(busy_a), .done(done_a)
  );

  pwm_ramp_sequencer #(.STEP(64), .DIV(1)) u_dut_b (
    .clk(clk), .reset(reset),
`ifdef PWM_RAMP_ABORT_EN
    .abort(abort),
`endif
    .period_tick(period_tick), .tgt_valid(valid_b), .tgt_ready(ready_b),
    .tgt_duty(tduty_b), .duty_cycle(duty_b), .busy(busy_b), .done(done_b)
  );

  pwm_ramp_sequencer #(.STEP(4), .DIV(3)) u_dut_c (
    .clk(clk), .reset(reset),
`ifdef PWM_RAMP_ABORT_EN
    .abort(abort),
`endif
    .period_tick(period_tick), .tgt_valid(valid_c), .tgt_ready(ready_c),
    .tgt_duty(tduty_c), .duty_cycle(duty_c), .busy(busy_c), .done(done_c)
  );

  always @(negedge clk) begin
    if (done_a === 1'b1) done_cnt_a++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the counting edge.
  task automatic pulse_tick();
    period_tick = 1'b1;
    @(negedge clk);
    period_tick = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    period_tick = 1'b0;
    valid_a = 1'b0; tduty_a = 8'd0;
    valid_b = 1'b0; tduty_b = 8'd0;
    valid_c = 1'b0; tduty_c = 8'd0;
`ifdef PWM_RAMP_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_duty", duty_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_ready", ready_a, 0);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_rst", ready_a, 1);

    // Ramp 0 -> 64, STEP 4, one tick every 256 cycles
    $display("[TB] accept A target 64");
    valid_a = 1'b1; tduty_a = 8'd64;
    @(negedge clk);
    valid_a = 1'b0;
    check("t1_busy", busy_a, 1);
    check("t1_ready", ready_a, 0);
    for (int i = 1; i <= 16; i++) begin
      repeat (255) @(negedge clk);
      check("t1_hold", duty_a, (i - 1) * 4);
      pulse_tick();
      check("t1_step", duty_a, i * 4);
    end
    check("t1_done", done_a, 1);
    check("t1_busy_end", busy_a, 0);
    check("t1_ready_end", ready_a, 1);
    @(negedge clk);
    check("t1_done_one", done_a, 0);
    check("t1_done_cnt", done_cnt_a, 1);

    // STEP 64: up to 200, then down to 10 with clamped final step
    $display("[TB] accept B target 200");
    valid_b = 1'b1; tduty_b = 8'd200;
    @(negedge clk);
    valid_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      repeat (2) @(negedge clk);
      pulse_tick();
      check("t2_up", duty_b, up_b[i]);
    end
    check("t2_up_done", done_b, 1);
    @(negedge clk);
    $display("[TB] accept B target 10");
    valid_b = 1'b1; tduty_b = 8'd10;
    @(negedge clk);
    valid_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      repeat (2) @(negedge clk);
      pulse_tick();
      check("t2_down", duty_b, down_b[i]);
    end
    check("t2_down_done", done_b, 1);
    check("t2_down_busy", busy_b, 0);

    // DIV 3 with a tick in the acceptance cycle
    $display("[TB] accept C target 8");
    valid_c = 1'b1; tduty_c = 8'd8; period_tick = 1'b1;
    @(negedge clk);
    valid_c = 1'b0; period_tick = 1'b0;
    check("t3_busy", busy_c, 1);
    check("t3_acc_duty", duty_c, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pulse_tick();
      check("t3_duty", duty_c, seq_c[i]);
    end
    check("t3_done", done_c, 1);
    check("t3_busy_end", busy_c, 0);

    // Valid during RAMP is ignored; then equal-target acceptance
    $display("[TB] accept A target 80");
    valid_a = 1'b1; tduty_a = 8'd80;
    @(negedge clk);
    tduty_a = 8'd255;
    check("t4_ready_ramp", ready_a, 0);
    for (int i = 1; i <= 4; i++) begin
      repeat (2) @(negedge clk);
      pulse_tick();
      if (i == 4) valid_a = 1'b0;
      check("t4_duty", duty_a, 64 + 4 * i);
    end
    check("t4_done", done_a, 1);
    @(negedge clk);
    $display("[TB] accept A equal target 80");
    valid_a = 1'b1; tduty_a = 8'd80;
    @(negedge clk);
    valid_a = 1'b0;
    check("t4_eq_done", done_a, 1);
    check("t4_eq_busy", busy_a, 0);
    check("t4_eq_duty", duty_a, 80);
    @(negedge clk);
    check("t4_eq_done_one", done_a, 0);

    // Reset in the middle of a ramp at duty 100
    $display("[TB] accept A target 120");
    valid_a = 1'b1; tduty_a = 8'd120;
    @(negedge clk);
    valid_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      pulse_tick();
    end
    check("t5_mid_duty", duty_a, 100);
    check("t5_mid_busy", busy_a, 1);
    reset = 1'b0;
    @(negedge clk);
    check("t5_rst_duty", duty_a, 0);
    check("t5_rst_busy", busy_a, 0);
    check("t5_rst_ready", ready_a, 0);
    @(negedge clk);
    check("t5_rst_ready2", ready_a, 0);
    reset = 1'b1;
    @(negedge clk);
    check("t5_ready_back", ready_a, 1);
    pulse_tick();
    check("t5_discard_duty", duty_a, 0);
    check("t5_discard_busy", busy_a, 0);

`ifdef PWM_RAMP_ABORT_EN
    // Abort together with a tick at duty 120
    begin
      int cnt_before;
      $display("[TB] accept A target 124 then abort");
      valid_a = 1'b1; tduty_a = 8'd124;
      @(negedge clk);
      valid_a = 1'b0;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        pulse_tick();
      end
      check("t6_pre_duty", duty_a, 120);
      cnt_before = done_cnt_a;
      abort = 1'b1; period_tick = 1'b1;
      @(negedge clk);
      abort = 1'b0; period_tick = 1'b0;
      check("t6_duty", duty_a, 0);
      check("t6_busy", busy_a, 0);
      check("t6_ready", ready_a, 1);
      check("t6_done", done_a, 0);
      @(negedge clk);
      check("t6_done_cnt", done_cnt_a, cnt_before);
      pulse_tick();
      check("t6_stay_duty", duty_a, 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
